adsr_voice_alloc: RTL and testbench
===================================

ADSR_VOICE_ALLOC -- requirements
Module: adsr_voice_alloc

Interface
REQ-001 SHALL have port clk  input  1  system clock, 100 MHz, all state on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have port req_valid  input  1  note-on request pending; requester holds it and req_note stable until accepted.
REQ-004 SHALL have port req_note  input  7  note number of the request.
REQ-005 SHALL have port req_ready  output  1  one-cycle accept strobe; transfer occurs when req_valid && req_ready.
REQ-006 SHALL have port voice_busy  input  4  per-voice flag from each adsr instance, 1 while its state is not idle.
REQ-007 SHALL have port voice_start  output  4  one-hot one-cycle start pulse to the adsr start input.
REQ-008 SHALL have port voice_kill  output  4  one-hot one-cycle force-to-idle pulse to the adsr instance.
REQ-009 SHALL have port voice_note  output  4x7  note currently assigned to each voice.
REQ-010 SHALL have port steal_count  output  16  number of voice steals, saturating.

Function
REQ-011 SHALL implement FSM states IDLE, KILL, WAIT_FREE, START; all outputs registered.
REQ-012 A voice SHALL be allocated while voice_busy[v] or pend[v] is 1; pend[v] set on voice_start[v], cleared on the first cycle voice_busy[v] is sampled 1.
REQ-013 In IDLE with req_valid=1: if any voice is unallocated, select the lowest-index one and go to START; else select the LRU voice and go to KILL.
REQ-014 KILL SHALL pulse voice_kill[sel] for exactly one cycle, increment steal_count (saturate at 16'hFFFF), and go to WAIT_FREE.
REQ-015 WAIT_FREE SHALL hold until voice_busy[sel]=0, then go to START; pend[sel] is cleared on kill.
REQ-016 START SHALL assert req_ready and voice_start[sel] in the same single cycle, load voice_note[sel]=req_note, mark sel MRU, and return to IDLE.
REQ-017 Latency, free voice: req_valid sampled in cycle t -> req_ready/voice_start in cycle t+1; next request can be sampled in t+2.
REQ-018 Latency, steal: req_valid at t -> voice_kill at t+1 -> voice_start no earlier than t+3.
REQ-019 LRU order SHALL be a 4-entry list of 2-bit voice indexes; START moves sel to the MRU position and shifts the others down one.
REQ-020 req_valid deasserting while not in START (protocol violation) SHALL not corrupt state; FSM completes the sequence and START issues voice_start without req_ready effect on the requester.
REQ-021 Voices going idle on their own (voice_busy falling) SHALL not change LRU order or voice_note.
REQ-022 voice_start and voice_kill SHALL never be asserted in the same cycle, and never more than one bit each.

Reset
REQ-023 While reset_n=1: state IDLE, req_ready=0, voice_start=0, voice_kill=0, pend=0, voice_note all 0, steal_count=0, LRU order {0 LRU,1,2,3 MRU}.
REQ-024 Reset asserted mid-sequence (any state) SHALL abort immediately with no further pulses; the pending request is not accepted.

Structure
REQ-025 Package adsr_pkg SHALL hold NUM_VOICES=4, VOICE_IDX_W=2, NOTE_W=7, and the FSM state enum.
REQ-026 Lowest-index free-voice selection SHALL be a sub-module voice_pick (4-bit mask in, index and found-flag out, combinational).
REQ-027 Top-level adsr_synth SHALL instantiate this block with four adsr instances sharing step/level/time configuration.

Verification
REQ-028 After reset, req_note=60 for one request, voice_busy=0 -> voice_start=4'b0001 one cycle after req_valid, voice_note[0]=60, req_ready one cycle.
REQ-029 Four back-to-back requests notes 60,62,64,65 with busy following starts -> voice_start 0001,0010,0100,1000 in order; steal_count=0.
REQ-030 Fifth request note 67 with all busy -> voice_kill=4'b0001, busy[0] dropped 1 cycle later, then voice_start=4'b0001, voice_note[0]=67, steal_count=1.
REQ-031 Sixth request note 69, all busy -> voice_kill=4'b0010 (LRU now voice 1), steal_count=2.
REQ-032 Voice 2 busy falls naturally, then request note 70 -> voice_start=4'b0100 with no kill.
REQ-033 Assert reset_n during WAIT_FREE -> no voice_start issued, all outputs at reset values, req_ready never pulsed.

Source files
------------

// File: rtl/adsr_pkg.sv
//------------------------------------------------------------------------------
// Module  : adsr_pkg
// Brief   : Shared sizes and FSM state type for the ADSR voice allocator.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package adsr_pkg;

  localparam int NUM_VOICES  = 4;
  localparam int VOICE_IDX_W = 2;
  localparam int NOTE_W      = 7;
  localparam int STEAL_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_KILL      = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_START     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adsr_voice_alloc_voice_pick.sv
//------------------------------------------------------------------------------
// Module  : voice_pick
// Brief   : Combinational lowest-index picker over a free-voice mask.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module voice_pick
  import adsr_pkg::*;
(
  input  logic [NUM_VOICES-1:0]  i_free,
  output logic [VOICE_IDX_W-1:0] o_idx,
  output logic                   o_found
);

  // Scan downward so the last hit is the lowest set index.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_idx   = VOICE_IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adsr_voice_alloc.sv
//------------------------------------------------------------------------------
// Module  : adsr_voice_alloc
// Brief   : Note-on voice allocator with LRU voice stealing for four ADSR voices.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adsr_voice_alloc
  import adsr_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  input  logic [NOTE_W-1:0]            req_note,
  output logic                         req_ready,
  input  logic [NUM_VOICES-1:0]        voice_busy,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic [NUM_VOICES-1:0]        voice_kill,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [STEAL_W-1:0]           steal_count
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [VOICE_IDX_W-1:0]   r_sel;
  logic [VOICE_IDX_W-1:0]   w_sel_nxt;
  logic [NUM_VOICES-1:0]    r_pend;
  logic [VOICE_IDX_W-1:0]   r_lru     [NUM_VOICES];
  logic [VOICE_IDX_W-1:0]   w_lru_mru [NUM_VOICES];
  logic [NUM_VOICES-1:0]    w_free;
  logic [VOICE_IDX_W-1:0]   w_free_idx;
  logic                     w_free_found;
  logic                     w_ready_nxt;
  logic [NUM_VOICES-1:0]    w_start_nxt;
  logic [NUM_VOICES-1:0]    w_kill_nxt;
  logic                     r_req_ready;
  logic [NUM_VOICES-1:0]    r_voice_start;
  logic [NUM_VOICES-1:0]    r_voice_kill;
  logic [NUM_VOICES*NOTE_W-1:0] r_notes;
  logic [STEAL_W-1:0]       r_steal;

  // A voice counts as allocated from its start pulse until busy is seen.
  assign w_free = ~(voice_busy | r_pend);

  voice_pick u_pick (
    .i_free  (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_free_found) begin
            w_sel_nxt   = w_free_idx;
            w_state_nxt = ST_START;
          end else begin
            w_sel_nxt   = r_lru[0];
            w_state_nxt = ST_KILL;
          end
        end
      end
      ST_KILL:      w_state_nxt = ST_WAIT_FREE;
      ST_WAIT_FREE: if (!voice_busy[r_sel]) w_state_nxt = ST_START;
      ST_START:     w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pulses land registered.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_start_nxt = '0;
    w_kill_nxt  = '0;
    case (w_state_nxt)
      ST_KILL:  w_kill_nxt = NUM_VOICES'(1) << w_sel_nxt;
      ST_START: begin
        w_ready_nxt = 1'b1;
        w_start_nxt = NUM_VOICES'(1) << w_sel_nxt;
      end
      default: ;
    endcase
  end

  // Index 0 is LRU; the chosen voice moves to the top, entries above it slide down.
  always_comb begin
    logic w_passed;
    w_passed = 1'b0;
    for (int i = 0; i < NUM_VOICES - 1; i++) begin
      if (r_lru[i] == w_sel_nxt) w_passed = 1'b1;
      w_lru_mru[i] = w_passed ? r_lru[i+1] : r_lru[i];
    end
    w_lru_mru[NUM_VOICES-1] = w_sel_nxt;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_req_ready   <= 1'b0;
      r_voice_start <= '0;
      r_voice_kill  <= '0;
      r_pend        <= '0;
      r_notes       <= '0;
      r_steal       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_lru[i] <= VOICE_IDX_W'(i);
    end else begin
      r_req_ready   <= w_ready_nxt;
      r_voice_start <= w_start_nxt;
      r_voice_kill  <= w_kill_nxt;
      r_pend        <= ((r_pend & ~voice_busy) | r_voice_start) & ~r_voice_kill;
      if ((w_kill_nxt != '0) && (r_steal != {STEAL_W{1'b1}}))
        r_steal <= r_steal + STEAL_W'(1);
      if (w_start_nxt != '0) begin
        r_notes[w_sel_nxt*NOTE_W +: NOTE_W] <= req_note;
        r_lru <= w_lru_mru;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign voice_start = r_voice_start;
  assign voice_kill  = r_voice_kill;
  assign voice_note  = r_notes;
  assign steal_count = r_steal;

endmodule

`default_nettype wire

// File: tb/tb_adsr_voice_alloc.sv
//------------------------------------------------------------------------------
// Module  : tb_adsr_voice_alloc
// Brief   : Self-checking bench: directed scenarios plus random note-on traffic
//           against a queue-based allocation model and a simple voice stand-in.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adsr_voice_alloc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [6:0]  req_note;
  logic        req_ready;
  logic [3:0]  voice_busy;
  logic [3:0]  voice_start;
  logic [3:0]  voice_kill;
  logic [27:0] voice_note;
  logic [15:0] steal_count;

  adsr_voice_alloc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_note    (req_note),
    .req_ready   (req_ready),
    .voice_busy  (voice_busy),
    .voice_start (voice_start),
    .voice_kill  (voice_kill),
    .voice_note  (voice_note),
    .steal_count (steal_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: usage order as a queue (front = least recently started).
  int       m_order[$];
  int       m_note[4];
  bit       m_pend[4];
  int       m_steals;
  int       m_phase;    // 0 accepting, 1 victim killed, 2 awaiting victim idle, 3 granting
  int       m_victim;
  bit [3:0] m_start;
  bit [3:0] m_kill;
  bit       m_ready;

  // Voice stand-in: busy rises some cycles after start, falls some cycles after kill.
  int env_on[4];
  int env_off[4];
  int start_dly_max;
  int kill_dly_min;
  int kill_dly_max;
  int rel_prob;

  bit [3:0] seen_start;
  bit [3:0] seen_kill;
  bit       seen_ready;
  int       last_lat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_order  = {0, 1, 2, 3};
    m_steals = 0;
    m_phase  = 0;
    m_victim = 0;
    m_start  = '0;
    m_kill   = '0;
    m_ready  = 1'b0;
    for (int v = 0; v < 4; v++) begin
      m_note[v] = 0;
      m_pend[v] = 1'b0;
    end
  endfunction

  function automatic void grant(input logic [6:0] note);
    int pos;
    pos = 0;
    m_start[m_victim] = 1'b1;
    m_ready = 1'b1;
    m_note[m_victim] = note;
    foreach (m_order[i]) if (m_order[i] == m_victim) pos = i;
    m_order.delete(pos);
    m_order.push_back(m_victim);
    m_phase = 3;
  endfunction

  function automatic void model_edge(input bit rst, input bit valid,
                                     input logic [6:0] note, input logic [3:0] busy);
    bit [3:0] prev_s;
    bit [3:0] prev_k;
    int pick;
    if (rst) begin
      model_reset();
      return;
    end
    prev_s  = m_start;
    prev_k  = m_kill;
    m_start = '0;
    m_kill  = '0;
    m_ready = 1'b0;
    case (m_phase)
      0: if (valid) begin
        pick = -1;
        for (int v = 3; v >= 0; v--) if (!busy[v] && !m_pend[v]) pick = v;
        if (pick >= 0) begin
          m_victim = pick;
          grant(note);
        end else begin
          m_victim = m_order[0];
          m_kill[m_victim] = 1'b1;
          if (m_steals < 65535) m_steals++;
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      2: if (!busy[m_victim]) grant(note);
      default: m_phase = 0;
    endcase
    for (int v = 0; v < 4; v++) begin
      if (prev_k[v])      m_pend[v] = 1'b0;
      else if (prev_s[v]) m_pend[v] = 1'b1;
      else if (busy[v])   m_pend[v] = 1'b0;
    end
  endfunction

  function automatic logic [27:0] model_notes();
    logic [27:0] r;
    r = '0;
    for (int v = 0; v < 4; v++) r[v*7 +: 7] = m_note[v][6:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_edge(reset_n, req_valid, req_note, voice_busy);
    check("req_ready",   {31'd0, req_ready},   {31'd0, m_ready});
    check("voice_start", {28'd0, voice_start}, {28'd0, m_start});
    check("voice_kill",  {28'd0, voice_kill},  {28'd0, m_kill});
    check("voice_note",  {4'd0, voice_note},   {4'd0, model_notes()});
    check("steal_count", {16'd0, steal_count}, m_steals);
    check("pulse_excl",
          {31'd0, ((voice_start != 0) && (voice_kill != 0)) ||
                  !$onehot0(voice_start) || !$onehot0(voice_kill)}, 32'd0);
    seen_start |= voice_start;
    seen_kill  |= voice_kill;
    seen_ready |= req_ready;
    if (reset_n) begin
      voice_busy = '0;
      for (int v = 0; v < 4; v++) begin
        env_on[v]  = -1;
        env_off[v] = -1;
      end
    end else begin
      for (int v = 0; v < 4; v++) begin
        if (voice_kill[v]) begin
          env_on[v] = -1;
          if (voice_busy[v]) env_off[v] = $urandom_range(kill_dly_max, kill_dly_min);
        end
        if (voice_start[v]) env_on[v] = $urandom_range(start_dly_max, 0);
        if (env_on[v] == 0) begin
          voice_busy[v] = 1'b1;
          env_on[v] = -1;
        end else if (env_on[v] > 0) env_on[v]--;
        if (env_off[v] == 0) begin
          voice_busy[v] = 1'b0;
          env_off[v] = -1;
        end else if (env_off[v] > 0) env_off[v]--;
        if (rel_prob > 0 && voice_busy[v] && env_on[v] < 0 && env_off[v] < 0 &&
            $urandom_range(rel_prob - 1, 0) == 0)
          voice_busy[v] = 1'b0;
      end
    end
  endtask

  task automatic do_request(input logic [6:0] note, input bit violate);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_note   = note;
    seen_start = '0;
    seen_kill  = '0;
    seen_ready = 1'b0;
    while (!seen_ready && n < 40) begin
      step();
      n++;
      if (violate && seen_kill != 0) req_valid = 1'b0;
    end
    last_lat = n;
    check("ready_seen", {31'd0, seen_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_note  = '0;
    voice_busy = '0;
    start_dly_max = 0;
    kill_dly_min  = 0;
    kill_dly_max  = 0;
    rel_prob      = 0;
    for (int v = 0; v < 4; v++) begin
      env_on[v]  = -1;
      env_off[v] = -1;
    end
    model_reset();
    repeat (3) step();
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_start", {28'd0, voice_start}, 32'd0);
    check("rst_kill",  {28'd0, voice_kill}, 32'd0);
    check("rst_notes", {4'd0, voice_note}, 32'd0);
    check("rst_steal", {16'd0, steal_count}, 32'd0);
    reset_n = 1'b0;
    step();

    do_request(7'd60, 1'b0);
    check("d1_start", {28'd0, seen_start}, 32'h1);
    check("d1_lat",   last_lat, 32'd1);
    check("d1_note0", {25'd0, voice_note[6:0]}, 32'd60);
    do_request(7'd62, 1'b0);
    check("d2_start", {28'd0, seen_start}, 32'h2);
    do_request(7'd64, 1'b0);
    check("d3_start", {28'd0, seen_start}, 32'h4);
    do_request(7'd65, 1'b0);
    check("d4_start", {28'd0, seen_start}, 32'h8);
    check("d4_steal", {16'd0, steal_count}, 32'd0);

    do_request(7'd67, 1'b0);
    check("d5_kill",  {28'd0, seen_kill}, 32'h1);
    check("d5_start", {28'd0, seen_start}, 32'h1);
    check("d5_lat",   last_lat, 32'd3);
    check("d5_note0", {25'd0, voice_note[6:0]}, 32'd67);
    check("d5_steal", {16'd0, steal_count}, 32'd1);

    do_request(7'd69, 1'b0);
    check("d6_kill",  {28'd0, seen_kill}, 32'h2);
    check("d6_note1", {25'd0, voice_note[13:7]}, 32'd69);
    check("d6_steal", {16'd0, steal_count}, 32'd2);

    voice_busy[2] = 1'b0;
    repeat (2) step();
    do_request(7'd70, 1'b0);
    check("d7_kill",  {28'd0, seen_kill}, 32'h0);
    check("d7_start", {28'd0, seen_start}, 32'h4);
    check("d7_note2", {25'd0, voice_note[20:14]}, 32'd70);

    // Abort a steal while it waits for the victim to go idle.
    kill_dly_min = 6;
    kill_dly_max = 6;
    req_valid  = 1'b1;
    req_note   = 7'd71;
    seen_kill  = '0;
    n = 0;
    while (seen_kill == 0 && n < 10) begin
      step();
      n++;
    end
    check("d8_kill", {28'd0, seen_kill}, 32'h8);
    step();
    reset_n    = 1'b1;
    seen_start = '0;
    seen_ready = 1'b0;
    repeat (4) step();
    check("d8_no_start", {28'd0, seen_start}, 32'd0);
    check("d8_no_ready", {31'd0, seen_ready}, 32'd0);
    check("d8_notes",    {4'd0, voice_note}, 32'd0);
    check("d8_steal",    {16'd0, steal_count}, 32'd0);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    step();

    start_dly_max = 2;
    kill_dly_min  = 0;
    kill_dly_max  = 3;
    rel_prob      = 30;
    for (int r = 0; r < 300; r++) begin
      repeat ($urandom_range(3, 0)) step();
      do_request(7'($urandom_range(127, 0)), $urandom_range(9, 0) == 0);
    end
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
